// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, FSM encoding and flag positions for alu_secuencial
package alu_pkg;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_SRA = 6'b000011;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } estado_t;

    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_CARRY = 1;
    localparam int FLAG_OVF   = 2;
    localparam int FLAG_ERR   = 3;
    localparam int NFLAGS     = 4;

endpackage

// File: rtl/alu_nucleo.sv
// rtl/alu_nucleo.sv - combinational core for add/sub/logic ops with carry, overflow and error
module alu_nucleo
    import alu_pkg::*;
#(
    parameter int NBITS  = 8,
    parameter int COD_OP = 6
) (
    input  logic [NBITS-1:0]  a_i,
    input  logic [NBITS-1:0]  b_i,
    input  logic [COD_OP-1:0] op_i,
    output logic [NBITS-1:0]  res_o,
    output logic              carry_o,
    output logic              overflow_o,
    output logic              error_o
);

    logic [NBITS:0] suma;
    logic [NBITS:0] resta;

    assign suma  = {1'b0, a_i} + {1'b0, b_i};
    // The extra MSB of the wide difference is the unsigned borrow (A < B).
    assign resta = {1'b0, a_i} - {1'b0, b_i};

    always_comb begin
        res_o      = '0;
        carry_o    = 1'b0;
        overflow_o = 1'b0;
        error_o    = 1'b0;
        case (op_i)
            COD_OP'(OP_ADD): begin
                res_o      = suma[NBITS-1:0];
                carry_o    = suma[NBITS];
                overflow_o = (a_i[NBITS-1] == b_i[NBITS-1]) &&
                             (suma[NBITS-1] != a_i[NBITS-1]);
            end
            COD_OP'(OP_SUB): begin
                res_o      = resta[NBITS-1:0];
                carry_o    = resta[NBITS];
                overflow_o = (a_i[NBITS-1] != b_i[NBITS-1]) &&
                             (resta[NBITS-1] != a_i[NBITS-1]);
            end
            COD_OP'(OP_AND): res_o = a_i & b_i;
            COD_OP'(OP_OR):  res_o = a_i | b_i;
            COD_OP'(OP_XOR): res_o = a_i ^ b_i;
            COD_OP'(OP_NOR): res_o = ~(a_i | b_i);
            // Shifts are handled by the sequential datapath in the top.
            COD_OP'(OP_SRL), COD_OP'(OP_SRA): res_o = '0;
            default: error_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_secuencial.sv
// rtl/alu_secuencial.sv - registered ALU with valid/ready handshake and iterative shifts
module alu_secuencial
    import alu_pkg::*;
#(
    parameter int NBITS  = 8,
    parameter int COD_OP = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [NBITS-1:0]  operando_A,
    input  logic [NBITS-1:0]  operando_B,
    input  logic [COD_OP-1:0] cod_operacion,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [NBITS-1:0]  ALU_Result,
    output logic              o_zero,
    output logic              o_carry,
    output logic              o_overflow,
    output logic              o_error
);

    localparam int CW = $clog2(NBITS + 1);

    estado_t           state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [NBITS-1:0]  sh_q, sh_d;
    logic              arith_q, arith_d;
    logic [NBITS-1:0]  res_q, res_d;
    logic [NFLAGS-1:0] flags_q, flags_d;
    logic              valid_q, valid_d;

    logic [NBITS-1:0]  nuc_res;
    logic              nuc_carry, nuc_ovf, nuc_err;
    logic              accept, es_shift;
    logic [CW-1:0]     shamt;
    logic [NBITS-1:0]  sh_next;

    alu_nucleo #(
        .NBITS  (NBITS),
        .COD_OP (COD_OP)
    ) u_nucleo (
        .a_i        (operando_A),
        .b_i        (operando_B),
        .op_i       (cod_operacion),
        .res_o      (nuc_res),
        .carry_o    (nuc_carry),
        .overflow_o (nuc_ovf),
        .error_o    (nuc_err)
    );

    assign o_ready = (state_q == ST_IDLE) && (!valid_q || i_ready);
    assign accept  = i_valid && o_ready;
    assign es_shift = (cod_operacion == COD_OP'(OP_SRL)) ||
                      (cod_operacion == COD_OP'(OP_SRA));
    // Amounts of NBITS or more behave identically, so clamp before counting.
    assign shamt   = (operando_B >= NBITS'(NBITS)) ? CW'(NBITS) : operando_B[CW-1:0];
    assign sh_next = {arith_q & sh_q[NBITS-1], sh_q[NBITS-1:1]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        arith_d = arith_q;
        res_d   = res_q;
        flags_d = flags_q;
        valid_d = valid_q;

        if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (es_shift && (shamt != '0)) begin
                        state_d = ST_SHIFT;
                        cnt_d   = shamt;
                        sh_d    = operando_A;
                        arith_d = (cod_operacion == COD_OP'(OP_SRA));
                    end else begin
                        res_d   = es_shift ? operando_A : nuc_res;
                        flags_d = '0;
                        flags_d[FLAG_ZERO]  = es_shift ? (operando_A == '0) : (nuc_res == '0);
                        flags_d[FLAG_CARRY] = es_shift ? 1'b0 : nuc_carry;
                        flags_d[FLAG_OVF]   = es_shift ? 1'b0 : nuc_ovf;
                        flags_d[FLAG_ERR]   = es_shift ? 1'b0 : nuc_err;
                        valid_d = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                sh_d  = sh_next;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = ST_IDLE;
                    res_d   = sh_next;
                    flags_d = '0;
                    flags_d[FLAG_ZERO]  = (sh_next == '0);
                    flags_d[FLAG_CARRY] = sh_q[0];
                    valid_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            arith_q <= 1'b0;
            res_q   <= '0;
            flags_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            arith_q <= arith_d;
            res_q   <= res_d;
            flags_q <= flags_d;
            valid_q <= valid_d;
        end
    end

    assign o_valid    = valid_q;
    assign ALU_Result = res_q;
    assign o_zero     = flags_q[FLAG_ZERO];
    assign o_carry    = flags_q[FLAG_CARRY];
    assign o_overflow = flags_q[FLAG_OVF];
    assign o_error    = flags_q[FLAG_ERR];

endmodule

// File: tb/tb_alu_secuencial.sv
// tb/tb_alu_secuencial.sv - scoreboard bench for alu_secuencial with directed vectors
module tb_alu_secuencial;
    import alu_pkg::*;

    typedef struct packed {
        logic [7:0] res;
        logic       z;
        logic       c;
        logic       v;
        logic       e;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_valid = 1'b0;
    logic       o_ready;
    logic [7:0] operando_A = '0;
    logic [7:0] operando_B = '0;
    logic [5:0] cod_operacion = '0;
    logic       o_valid;
    logic       i_ready = 1'b1;
    logic [7:0] ALU_Result;
    logic       o_zero, o_carry, o_overflow, o_error;

    int   checks = 0;
    int   fails  = 0;
    exp_t sb[$];

    alu_secuencial #(.NBITS(8), .COD_OP(6)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .operando_A    (operando_A),
        .operando_B    (operando_B),
        .cod_operacion (cod_operacion),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .ALU_Result    (ALU_Result),
        .o_zero        (o_zero),
        .o_carry       (o_carry),
        .o_overflow    (o_overflow),
        .o_error       (o_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && o_valid && i_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 32'(ALU_Result), 32'hDEAD);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", 32'(ALU_Result), 32'(e.res));
                check("flags_zcve", 32'({o_zero, o_carry, o_overflow, o_error}),
                      32'({e.z, e.c, e.v, e.e}));
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b,
                         input exp_t e);
        bit done = 0;
        operando_A    = a;
        operando_B    = b;
        cod_operacion = op;
        i_valid       = 1'b1;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            if (o_ready) begin
                sb.push_back(e);
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) check("accept_timeout", 32'd0, 32'd1);
        i_valid = 1'b0;
    endtask

    task automatic latency(output int lat, output int rdy_low);
        bit seen = 0;
        lat = 1;
        rdy_low = 0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            if (o_valid) seen = 1;
            else begin
                if (!o_ready) rdy_low++;
                @(posedge clk);
                #1;
                lat++;
            end
        end
        if (!seen) check("valid_timeout", 32'd0, 32'd1);
        else begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic exp_t mk(input logic [7:0] r, input logic z, input logic c,
                                input logic v, input logic e);
        mk = '{res: r, z: z, c: c, v: v, e: e};
    endfunction

    int lat, rl;

    initial begin
        #2;
        check("reset_valid", 32'(o_valid), 32'd0);
        check("reset_result", 32'(ALU_Result), 32'd0);
        check("reset_flags", 32'({o_zero, o_carry, o_overflow, o_error}), 32'd0);
        check("reset_ready", 32'(o_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        issue(OP_ADD, 8'h04, 8'h0C, mk(8'h10, 0, 0, 0, 0));
        latency(lat, rl);
        check("add_latency", 32'(lat), 32'd1);
        issue(OP_SUB, 8'h04, 8'h0C, mk(8'hF8, 0, 1, 0, 0));
        issue(OP_ADD, 8'h7F, 8'h01, mk(8'h80, 0, 0, 1, 0));
        issue(OP_ADD, 8'hFF, 8'h01, mk(8'h00, 1, 1, 0, 0));
        issue(OP_SUB, 8'h80, 8'h01, mk(8'h7F, 0, 0, 1, 0));
        issue(OP_OR,  8'h50, 8'h0A, mk(8'h5A, 0, 0, 0, 0));
        issue(OP_XOR, 8'hFF, 8'h0F, mk(8'hF0, 0, 0, 0, 0));
        issue(OP_NOR, 8'h00, 8'h00, mk(8'hFF, 0, 0, 0, 0));
        issue(6'b111111, 8'h12, 8'h34, mk(8'h00, 1, 0, 0, 1));
        issue(OP_SRL, 8'h81, 8'h00, mk(8'h81, 0, 0, 0, 0));
        latency(lat, rl);
        check("shift0_latency", 32'(lat), 32'd1);

        issue(OP_SRA, 8'h90, 8'h03, mk(8'hF2, 0, 0, 0, 0));
        latency(lat, rl);
        check("sra3_latency", 32'(lat), 32'd4);
        check("sra3_ready_low", 32'(rl), 32'd3);
        issue(OP_SRL, 8'h90, 8'h09, mk(8'h00, 1, 1, 0, 0));
        latency(lat, rl);
        check("srl9_latency", 32'(lat), 32'd9);
        issue(OP_SRA, 8'h80, 8'hC8, mk(8'hFF, 0, 1, 0, 0));
        latency(lat, rl);
        check("sra_clamp_latency", 32'(lat), 32'd9);

        i_ready = 1'b0;
        issue(OP_ADD, 8'h04, 8'h0C, mk(8'h10, 0, 0, 0, 0));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_result", 32'(ALU_Result), 32'h10);
            check("bp_valid", 32'(o_valid), 32'd1);
            check("bp_ready", 32'(o_ready), 32'd0);
        end
        @(posedge clk); #1;
        i_ready = 1'b1;
        issue(OP_AND, 8'h04, 8'h0C, mk(8'h04, 0, 0, 0, 0));
        @(negedge clk);
        check("no_bubble_valid", 32'(o_valid), 32'd1);
        @(posedge clk); #1;

        issue(OP_SRA, 8'h90, 8'h05, mk(8'h00, 0, 0, 0, 0));
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        sb.delete();
        check("rst_mid_valid", 32'(o_valid), 32'd0);
        check("rst_mid_result", 32'(ALU_Result), 32'd0);
        check("rst_mid_flags", 32'({o_zero, o_carry, o_overflow, o_error}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", 32'(o_ready), 32'd1);
        @(posedge clk); #1;
        issue(OP_ADD, 8'h22, 8'h11, mk(8'h33, 0, 0, 0, 0));
        latency(lat, rl);
        check("post_rst_latency", 32'(lat), 32'd1);

        for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge clk);
        @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
